p_gpio: RTL and testbench
=========================

P_GPIO -- requirements
Module: p_gpio

Interface
REQ-001 SHALL have parameter XLEN, default 32: bus data/address width.
REQ-002 SHALL have parameter WIDTH, default 8: pin count; legal range 1..XLEN.
REQ-003 SHALL have parameter SYNC_STAGES, default 2: input synchronizer depth; legal range 2..4.
REQ-004 SHALL have port clk, input, 1: single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset; reset=0 resets the block.
REQ-006 SHALL have bus inputs bus_valid 1, bus_rw 1 (1=write), bus_addr XLEN, bus_wdata XLEN, bus_wstrb XLEN/8 and bus_size 3.
REQ-007 SHALL have bus outputs bus_ready 1, bus_rdata XLEN, bus_denied 1 and bus_corrupt 1.
REQ-008 SHALL have port gpio_in, input, WIDTH: raw pin inputs, asynchronous to clk.
REQ-009 SHALL have ports gpio_out (output, WIDTH, pin drive value) and gpio_oe (output, WIDTH, 1=pin drives).
REQ-010 SHALL have port irq, output, 1: level interrupt, OR of (IRQ_STATUS & (RISE_EN|FALL_EN)).

Function
REQ-011 SHALL decode offset bus_addr[5:0] as follows:
- 0x00 OUT: read/write.
- 0x04 DIR: read/write, drives gpio_oe.
- 0x08 IN: read-only, synchronized pins.
- 0x0C SET: write-1-set OUT.
- 0x10 CLR: write-1-clear OUT.
- 0x14 TGL: write-1-toggle OUT.
- 0x18 RISE_EN: read/write.
- 0x1C FALL_EN: read/write.
- 0x20 IRQ_STATUS: read, write-1-clear.
REQ-012 SHALL use a two-state handshake FSM:
- IDLE: accepts a request when bus_valid=1.
- RESP: asserts bus_ready for exactly one cycle with rdata/denied valid, then returns to IDLE.
- Latency is 1 cycle; back-to-back requests are accepted no earlier than the cycle after ready.
REQ-013 SHALL assert bus_denied with bus_ready, with no register change, for any of:
- unmapped offset;
- bus_addr[1:0]!=0;
- bus_size>2;
- a write to IN.
REQ-014 SHALL apply writes per byte lane under bus_wstrb; SET/CLR/TGL/W1C act only on strobed lanes.
REQ-015 SHALL zero-extend register bits above WIDTH on read; written upper bits SHALL be ignored.
REQ-016 SHALL drive bus_rdata=0 on writes and denied accesses, and hold bus_corrupt at 0.
REQ-017 SHALL pass gpio_in through SYNC_STAGES flops, then one history flop; rising/falling edges are detected from the synchronized value versus the history.
REQ-018 SHALL set an IRQ_STATUS bit on an enabled edge; disabled edges SHALL not set status.
REQ-019 SHALL give edge-set priority over a same-cycle W1C of the same IRQ_STATUS bit.
REQ-020 SHALL make IN read the last synchronized value regardless of DIR.
REQ-021 SHALL register gpio_out, gpio_oe and irq, each updating the cycle after the causing event.
REQ-022 SHALL keep a request accepted in IDLE unaffected by later bus_valid changes.

Reset
REQ-023 SHALL, while reset=0, asynchronously force:
- OUT, DIR, RISE_EN, FALL_EN, IRQ_STATUS, synchronizer and history flops to 0;
- the FSM to IDLE;
- bus_ready, bus_denied, bus_rdata, irq, gpio_out and gpio_oe to 0.
REQ-024 SHALL drop an in-flight transaction on reset mid-operation, with no ready pulse after reset release.
REQ-025 SHALL suppress edge detection on the first cycle after reset release.

Structure
REQ-026 SHALL place register offset constants and the FSM state enum in package p_gpio_pkg.
REQ-027 SHALL implement the synchronizer as sub-module p_sync, parameterised by WIDTH and STAGES.

Verification
REQ-028 SHALL cover: write OUT=0xA5 (wstrb=0xF), then DIR=0xFF -> gpio_out=0xA5 and gpio_oe=0xFF; each access gives a one-cycle bus_ready, 1 cycle after valid.
REQ-029 SHALL cover: OUT=0xF0, then SET=0x0F, CLR=0x30, TGL=0x81 -> OUT reads 0x4E.
REQ-030 SHALL cover: RISE_EN=0x01, gpio_in[0] 0->1 -> IRQ_STATUS=0x01 and irq=1 within SYNC_STAGES+2 cycles; W1C 0x01 -> irq=0.
REQ-031 SHALL cover: a falling edge on pin 2 with FALL_EN=0x04 in the same cycle as W1C of 0x04 -> IRQ_STATUS bit 2 remains 1.
REQ-032 SHALL cover: accesses to offset 0x24, to addr 0x02, and a write to IN -> bus_denied=1 with bus_ready, and no register changes.
REQ-033 SHALL cover: reset=0 asserted in the RESP state -> all outputs 0 immediately, and no bus_ready after release.

Source files
------------

// File: rtl/p_gpio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : p_gpio_pkg
// Description : Register offsets, handshake FSM states and a small decode
//               helper shared by the p_gpio block.
// Revision    : 1.0 - initial release
// ============================================================================
package p_gpio_pkg;

  // Register offsets within the 64-byte window (bus_addr[5:0])
  localparam logic [5:0] OFF_OUT        = 6'h00;
  localparam logic [5:0] OFF_DIR        = 6'h04;
  localparam logic [5:0] OFF_IN         = 6'h08;
  localparam logic [5:0] OFF_SET        = 6'h0C;
  localparam logic [5:0] OFF_CLR        = 6'h10;
  localparam logic [5:0] OFF_TGL        = 6'h14;
  localparam logic [5:0] OFF_RISE_EN    = 6'h18;
  localparam logic [5:0] OFF_FALL_EN    = 6'h1C;
  localparam logic [5:0] OFF_IRQ_STATUS = 6'h20;

  // Largest legal bus_size encoding (word access)
  localparam logic [2:0] MAX_SIZE = 3'd2;

  // Bus handshake states
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

  // True when the offset names one of the implemented registers
  function automatic logic is_mapped(input logic [5:0] off);
    logic hit;
    hit = 1'b0;
    case (off)
      OFF_OUT, OFF_DIR, OFF_IN, OFF_SET, OFF_CLR, OFF_TGL,
      OFF_RISE_EN, OFF_FALL_EN, OFF_IRQ_STATUS: hit = 1'b1;
      default:                                  hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage
`default_nettype wire

// File: rtl/p_sync.sv
`default_nettype none
// ============================================================================
// Module      : p_sync
// Description : Multi-flop synchronizer bringing asynchronous pin levels into
//               the clk domain. Output is the last stage of the chain.
// Revision    : 1.0 - initial release
// ============================================================================
module p_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] stage_q;

  // Shift the raw pin levels through the synchronizer chain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[STAGES-2:0], d};
    end
  end

  assign q = stage_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/p_gpio.sv
`default_nettype none
// ============================================================================
// Module      : p_gpio
// Description : Memory-mapped GPIO block with output/direction registers,
//               atomic set/clear/toggle, synchronized inputs and per-pin
//               rising/falling edge interrupts behind a one-cycle handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module p_gpio #(
  parameter int XLEN        = 32,
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bus_valid,
  input  logic              bus_rw,
  input  logic [XLEN-1:0]   bus_addr,
  input  logic [XLEN-1:0]   bus_wdata,
  input  logic [XLEN/8-1:0] bus_wstrb,
  input  logic [2:0]        bus_size,
  output logic              bus_ready,
  output logic [XLEN-1:0]   bus_rdata,
  output logic              bus_denied,
  output logic              bus_corrupt,
  input  logic [WIDTH-1:0]  gpio_in,
  output logic [WIDTH-1:0]  gpio_out,
  output logic [WIDTH-1:0]  gpio_oe,
  output logic              irq
);

  import p_gpio_pkg::*;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  out_q, dir_q, rise_q, fall_q, status_q;
  logic [WIDTH-1:0]  out_d, dir_d, rise_d, fall_d, status_d;
  logic [WIDTH-1:0]  sync_val, hist_q;
  logic              armed_q;
  logic              irq_q;
  logic [XLEN-1:0]   rdata_q;
  logic              denied_q;

  logic [5:0]        offset;
  logic              accept;
  logic              deny;
  logic              do_write;
  logic [XLEN-1:0]   lane_mask;
  logic [WIDTH-1:0]  wkeep, wbits, w1c;
  logic [WIDTH-1:0]  rd_val;
  logic [WIDTH-1:0]  rise_evt, fall_evt, edge_set;
  logic              unused_bits;

  // --------------------------------------------------------------------------
  // Input synchronizer
  // --------------------------------------------------------------------------
  p_sync #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (gpio_in),
    .q     (sync_val)
  );

  // Expand byte strobes to a per-bit write mask
  for (genvar g = 0; g < XLEN / 8; g++) begin : g_lane
    assign lane_mask[g*8 +: 8] = {8{bus_wstrb[g]}};
  end

  // Address bits above the window, data above WIDTH and unused lanes are
  // intentionally ignored.
  assign unused_bits = ^{bus_addr, bus_wdata, lane_mask};

  assign offset   = bus_addr[5:0];
  assign accept   = (state_q == ST_IDLE) && bus_valid;
  assign deny     = !is_mapped(offset) || (bus_addr[1:0] != 2'b00) ||
                    (bus_size > MAX_SIZE) || (bus_rw && (offset == OFF_IN));
  assign do_write = accept && bus_rw && !deny;
  assign wkeep    = lane_mask[WIDTH-1:0];
  assign wbits    = bus_wdata[WIDTH-1:0] & wkeep;

  // Edges are measured against the history flop; the first cycle after
  // reset release is masked so stale history cannot raise status.
  assign rise_evt = sync_val & ~hist_q;
  assign fall_evt = ~sync_val & hist_q;
  assign edge_set = ((rise_evt & rise_q) | (fall_evt & fall_q)) & {WIDTH{armed_q}};

  // --------------------------------------------------------------------------
  // Handshake FSM
  // --------------------------------------------------------------------------

  // State register for the request/response handshake
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: a request in IDLE yields exactly one RESP cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus_valid) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Register file
  // --------------------------------------------------------------------------

  // Read mux; write-only command registers read back as zero
  always_comb begin
    rd_val = '0;
    case (offset)
      OFF_OUT:        rd_val = out_q;
      OFF_DIR:        rd_val = dir_q;
      OFF_IN:         rd_val = sync_val;
      OFF_RISE_EN:    rd_val = rise_q;
      OFF_FALL_EN:    rd_val = fall_q;
      OFF_IRQ_STATUS: rd_val = status_q;
      default:        rd_val = '0;
    endcase
  end

  // Next register values; edge-set is applied after W1C so it wins a tie
  always_comb begin
    out_d  = out_q;
    dir_d  = dir_q;
    rise_d = rise_q;
    fall_d = fall_q;
    w1c    = '0;
    if (do_write) begin
      case (offset)
        OFF_OUT:        out_d  = (out_q  & ~wkeep) | wbits;
        OFF_DIR:        dir_d  = (dir_q  & ~wkeep) | wbits;
        OFF_SET:        out_d  = out_q | wbits;
        OFF_CLR:        out_d  = out_q & ~wbits;
        OFF_TGL:        out_d  = out_q ^ wbits;
        OFF_RISE_EN:    rise_d = (rise_q & ~wkeep) | wbits;
        OFF_FALL_EN:    fall_d = (fall_q & ~wkeep) | wbits;
        OFF_IRQ_STATUS: w1c    = wbits;
        default:        w1c    = '0;
      endcase
    end
    status_d = (status_q & ~w1c) | edge_set;
  end

  // Control/status registers plus the registered interrupt level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q    <= '0;
      dir_q    <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      status_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      out_q    <= out_d;
      dir_q    <= dir_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      status_q <= status_d;
      irq_q    <= |(status_d & (rise_d | fall_d));
    end
  end

  // Edge history and the post-reset arming flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      hist_q  <= sync_val;
      armed_q <= 1'b1;
    end
  end

  // Response data captured at acceptance, cleared once the response is gone
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q  <= '0;
      denied_q <= 1'b0;
    end else if (accept) begin
      rdata_q  <= (bus_rw || deny) ? {XLEN{1'b0}} : XLEN'(rd_val);
      denied_q <= deny;
    end else begin
      rdata_q  <= '0;
      denied_q <= 1'b0;
    end
  end

  assign bus_ready   = (state_q == ST_RESP);
  assign bus_rdata   = rdata_q;
  assign bus_denied  = denied_q;
  assign bus_corrupt = 1'b0;
  assign gpio_out    = out_q;
  assign gpio_oe     = dir_q;
  assign irq         = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_p_gpio.sv
`default_nettype none
// ============================================================================
// Module      : tb_p_gpio
// Description : Scoreboard bench for p_gpio: directed scenarios followed by
//               randomized bus traffic and pin activity against a register-
//               level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_p_gpio;

  localparam int XLEN = 32;
  localparam int W    = 8;
  localparam int SYNC = 2;

  typedef struct packed {
    logic [31:0] rdata;
    logic        denied;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              bus_valid = 1'b0;
  logic              bus_rw = 1'b0;
  logic [XLEN-1:0]   bus_addr = '0;
  logic [XLEN-1:0]   bus_wdata = '0;
  logic [XLEN/8-1:0] bus_wstrb = '0;
  logic [2:0]        bus_size = '0;
  logic              bus_ready;
  logic [XLEN-1:0]   bus_rdata;
  logic              bus_denied;
  logic              bus_corrupt;
  logic [W-1:0]      gpio_in = '0;
  logic [W-1:0]      gpio_out;
  logic [W-1:0]      gpio_oe;
  logic              irq;

  int   compared   = 0;
  int   mismatched = 0;
  exp_t exp_q[$];

  // Reference model state
  logic [7:0] m_out = '0, m_dir = '0, m_rise = '0, m_fall = '0, m_stat = '0, m_pins = '0;

  p_gpio #(.XLEN(XLEN), .WIDTH(W), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset),
    .bus_valid(bus_valid), .bus_rw(bus_rw), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_size(bus_size),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata), .bus_denied(bus_denied),
    .bus_corrupt(bus_corrupt),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Register-level behaviour: all 8 pins sit in byte lane 0
  task automatic model_access(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] strb, input logic [2:0] size,
                              output logic [31:0] rd, output logic den);
    logic [5:0] off;
    logic [7:0] m, d;
    off = addr[5:0];
    m   = strb[0] ? 8'hFF : 8'h00;
    d   = wdata[7:0] & m;
    den = (off > 6'h20) || (off % 4 != 0) || (addr[1:0] != 2'b00) || (size > 3'd2) ||
          (rw && off == 6'h08);
    rd  = 32'h0;
    if (den) return;
    if (!rw) begin
      case (off)
        6'h00: rd = {24'h0, m_out};
        6'h04: rd = {24'h0, m_dir};
        6'h08: rd = {24'h0, m_pins};
        6'h18: rd = {24'h0, m_rise};
        6'h1C: rd = {24'h0, m_fall};
        6'h20: rd = {24'h0, m_stat};
        default: rd = 32'h0;
      endcase
    end else begin
      case (off)
        6'h00: m_out  = (m_out  & ~m) | d;
        6'h04: m_dir  = (m_dir  & ~m) | d;
        6'h0C: m_out  = m_out | d;
        6'h10: m_out  = m_out & ~d;
        6'h14: m_out  = m_out ^ d;
        6'h18: m_rise = (m_rise & ~m) | d;
        6'h1C: m_fall = (m_fall & ~m) | d;
        6'h20: m_stat = m_stat & ~d;
        default: ;
      endcase
    end
  endtask

  // One bus transaction; post_set models an edge landing in the same cycle
  task automatic bus(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] strb, input logic [2:0] size,
                     input logic [7:0] post_set = 8'h00);
    exp_t e;
    model_access(rw, addr, wdata, strb, size, e.rdata, e.denied);
    m_stat = m_stat | post_set;
    @(negedge clk);
    bus_valid = 1'b1; bus_rw = rw; bus_addr = addr;
    bus_wdata = wdata; bus_wstrb = strb; bus_size = size;
    exp_q.push_back(e);
    @(posedge clk); #1;
    bus_valid = 1'b0;
    bus_addr  = $urandom; bus_wdata = $urandom; bus_rw = 1'($urandom);
    bus_wstrb = 4'($urandom); bus_size = 3'($urandom);
    @(posedge clk); #1;
    chk("response_latency", 32'(exp_q.size()), 32'd0);
    chk("gpio_out", {24'h0, gpio_out}, {24'h0, m_out});
    chk("gpio_oe", {24'h0, gpio_oe}, {24'h0, m_dir});
    chk("irq", {31'h0, irq}, {31'h0, |(m_stat & (m_rise | m_fall))});
  endtask

  // Change pins while the bus is quiet and let the edges settle
  task automatic set_pins(input logic [7:0] v);
    m_stat = m_stat | (v & ~m_pins & m_rise) | (~v & m_pins & m_fall);
    m_pins = v;
    @(negedge clk);
    gpio_in = v;
    repeat (SYNC + 3) @(posedge clk);
    #1;
    chk("irq_after_pins", {31'h0, irq}, {31'h0, |(m_stat & (m_rise | m_fall))});
  endtask

  // Monitor: every ready pulse must match the oldest outstanding expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && bus_ready) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL spurious_ready: ready=1 with nothing outstanding, required 0");
        end else begin
          e = exp_q.pop_front();
          chk("rdata", bus_rdata, e.rdata);
          chk("denied", {31'h0, bus_denied}, {31'h0, e.denied});
          chk("corrupt", {31'h0, bus_corrupt}, 32'h0);
        end
      end
    end
  end

  initial begin
    logic       got;
    logic       rw;
    logic [5:0] off;
    logic [2:0] size;
    logic [3:0] strb;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'h0, bus_ready}, 32'h0);
    chk("rst_rdata", bus_rdata, 32'h0);
    chk("rst_denied", {31'h0, bus_denied}, 32'h0);
    chk("rst_out", {24'h0, gpio_out}, 32'h0);
    chk("rst_oe", {24'h0, gpio_oe}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    for (int a = 0; a <= 'h20; a += 4) bus(1'b0, 32'(a), 32'h0, 4'hF, 3'd2);

    // OUT / DIR drive the pins
    bus(1'b1, 32'h00, 32'hA5, 4'hF, 3'd2);
    bus(1'b1, 32'h04, 32'hFF, 4'hF, 3'd2);
    chk("out_a5", {24'h0, gpio_out}, 32'hA5);
    chk("oe_ff", {24'h0, gpio_oe}, 32'hFF);

    // Atomic set/clear/toggle
    bus(1'b1, 32'h00, 32'hF0, 4'hF, 3'd2);
    bus(1'b1, 32'h0C, 32'h0F, 4'hF, 3'd2);
    bus(1'b1, 32'h10, 32'h30, 4'hF, 3'd2);
    bus(1'b1, 32'h14, 32'h81, 4'hF, 3'd2);
    bus(1'b0, 32'h00, 32'h0, 4'hF, 3'd2);
    chk("out_4e", {24'h0, gpio_out}, 32'h4E);

    // Rising-edge interrupt and W1C
    bus(1'b1, 32'h18, 32'h01, 4'hF, 3'd2);
    m_stat = m_stat | (8'h01 & ~m_pins & m_rise);
    m_pins = 8'h01;
    @(negedge clk);
    gpio_in = 8'h01;
    got = 1'b0;
    for (int i = 0; i < SYNC + 2 && !got; i++) begin
      @(posedge clk); #1;
      if (irq) got = 1'b1;
    end
    chk("irq_rise_latency", {31'h0, got}, 32'h1);
    bus(1'b0, 32'h20, 32'h0, 4'hF, 3'd2);
    bus(1'b1, 32'h20, 32'h01, 4'hF, 3'd2);
    chk("irq_cleared", {31'h0, irq}, 32'h0);

    // Edge-set beats a same-cycle W1C
    bus(1'b1, 32'h1C, 32'h04, 4'hF, 3'd2);
    set_pins(8'h05);
    set_pins(8'h01);
    set_pins(8'h05);
    m_pins = 8'h01;
    @(negedge clk);
    gpio_in = 8'h01;
    repeat (SYNC) @(posedge clk);
    bus(1'b1, 32'h20, 32'h04, 4'hF, 3'd2, 8'h04);
    chk("irq_edge_priority", {31'h0, irq}, 32'h1);
    bus(1'b0, 32'h20, 32'h0, 4'hF, 3'd2);

    // Denied accesses leave registers untouched
    bus(1'b1, 32'h24, 32'hFF, 4'hF, 3'd2);
    bus(1'b0, 32'h24, 32'h0, 4'hF, 3'd2);
    bus(1'b1, 32'h02, 32'hFF, 4'hF, 3'd2);
    bus(1'b1, 32'h08, 32'hFF, 4'hF, 3'd2);
    bus(1'b1, 32'h00, 32'h11, 4'hF, 3'd3);
    for (int a = 0; a <= 'h20; a += 4) bus(1'b0, 32'(a), 32'h0, 4'hF, 3'd2);

    // Reset during RESP
    set_pins(8'h00);
    bus(1'b1, 32'h00, 32'h3C, 4'hF, 3'd2);
    @(negedge clk);
    bus_valid = 1'b1; bus_rw = 1'b0; bus_addr = 32'h0; bus_size = 3'd2; bus_wstrb = 4'hF;
    @(posedge clk); #1;
    bus_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("mid_rst_ready", {31'h0, bus_ready}, 32'h0);
    chk("mid_rst_rdata", bus_rdata, 32'h0);
    chk("mid_rst_denied", {31'h0, bus_denied}, 32'h0);
    chk("mid_rst_out", {24'h0, gpio_out}, 32'h0);
    chk("mid_rst_oe", {24'h0, gpio_oe}, 32'h0);
    chk("mid_rst_irq", {31'h0, irq}, 32'h0);
    m_out = '0; m_dir = '0; m_rise = '0; m_fall = '0; m_stat = '0; m_pins = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_ready_after_rst", {31'h0, bus_ready}, 32'h0);
    end

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        set_pins(8'($urandom));
      end else begin
        rw   = 1'($urandom);
        off  = 6'($urandom_range(0, 15) * 4);
        if ($urandom_range(0, 9) == 0) off = off | 6'($urandom_range(1, 3));
        size = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        strb = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
        bus(rw, ($urandom & 32'hFFFF_FFC0) | {26'h0, off}, $urandom, strb, size);
      end
    end

    repeat (5) @(posedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
